// File: rtl/branch_predictor.sv
// Dynamic branch-direction predictor: PC-indexed table of 2-bit saturating counters
// with branch and mispredict statistics.
module branch_predictor #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned IDX_W = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  pc_f,
    output logic             pred_taken,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic [4:0]       upd_brop,
    input  logic             upd_taken,
    input  logic             upd_pred,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count,
    output logic             mispredict
);

    localparam int unsigned ENTRIES = 1 << IDX_W;

    logic [1:0]       cnt [ENTRIES];
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             upd_valid;
    logic             unused_pc_bits;

    assign rd_idx     = pc_f[IDX_W+1:2];
    assign wr_idx     = upd_pc[IDX_W+1:2];
    assign pred_taken = cnt[rd_idx][1];

    // Untagged table: only the index bits of either PC participate.
    assign unused_pc_bits = ^{pc_f[XLEN-1:IDX_W+2], pc_f[1:0],
                              upd_pc[XLEN-1:IDX_W+2], upd_pc[1:0]};

    // Only conditional BrOps train; an X selector falls to default and is ignored.
    always_comb begin
        upd_valid = 1'b0;
        case (upd_brop)
            5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6: upd_valid = 1'b1;
            default:                             upd_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                cnt[IDX_W'(i)] <= 2'b01;
            end
            br_count      <= '0;
            mispred_count <= '0;
            mispredict    <= 1'b0;
        end else begin
            mispredict <= 1'b0;
            if (upd_valid) begin
                if (upd_taken) begin
                    if (cnt[wr_idx] != 2'b11) cnt[wr_idx] <= cnt[wr_idx] + 2'd1;
                end else begin
                    if (cnt[wr_idx] != 2'b00) cnt[wr_idx] <= cnt[wr_idx] - 2'd1;
                end
                br_count <= br_count + CNT_W'(1);
                if (upd_pred != upd_taken) begin
                    mispred_count <= mispred_count + CNT_W'(1);
                    mispredict    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor; a second instance with
// 4-bit statistics counters checks counter wrap-around.
module tb_branch_predictor;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] pc_f;
    logic [XLEN-1:0] upd_pc;
    logic [4:0]      upd_brop;
    logic            upd_taken;
    logic            upd_pred;

    logic            pred_taken;
    logic [31:0]     br_count;
    logic [31:0]     mispred_count;
    logic            mispredict;

    logic            pred_taken4;
    logic [3:0]      br_count4;
    logic [3:0]      mispred_count4;
    logic            mispredict4;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    branch_predictor #(.XLEN(32), .IDX_W(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .pc_f(pc_f), .pred_taken(pred_taken),
        .upd_pc(upd_pc), .upd_brop(upd_brop), .upd_taken(upd_taken), .upd_pred(upd_pred),
        .br_count(br_count), .mispred_count(mispred_count), .mispredict(mispredict)
    );

    branch_predictor #(.XLEN(32), .IDX_W(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .pc_f(pc_f), .pred_taken(pred_taken4),
        .upd_pc(upd_pc), .upd_brop(upd_brop), .upd_taken(upd_taken), .upd_pred(upd_pred),
        .br_count(br_count4), .mispred_count(mispred_count4), .mispredict(mispredict4)
    );

    // One update applied at the next rising edge; returns #1 after that edge with brop back to NOP.
    task automatic apply_update(input logic [31:0] pc, input logic [4:0] brop,
                                input logic taken, input logic pred);
        @(negedge clk);
        upd_pc    = pc;
        upd_brop  = brop;
        upd_taken = taken;
        upd_pred  = pred;
        @(posedge clk);
        #1;
        upd_brop = 5'b00000;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        upd_brop = 5'b00000; upd_pc = '0; upd_taken = 1'b0; upd_pred = 1'b0; pc_f = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pc_f = 32'(i * 4);
            #1;
            tests_run++;
            if (pred_taken !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_pred pc=%h got=%b exp=0", pc_f, pred_taken);
            end
        end
        tests_run++;
        if (br_count !== 32'd0 || mispred_count !== 32'd0 || mispredict !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_counters got br=%0d mis=%0d pulse=%b exp 0/0/0",
                     br_count, mispred_count, mispredict);
        end
    endtask

    task automatic test_training();
        logic exp_pred [4];
        exp_pred[0] = 1'b1; exp_pred[1] = 1'b0; exp_pred[2] = 1'b0; exp_pred[3] = 1'b0;
        pc_f = 32'h10;
        apply_update(32'h10, 5'b00001, 1'b1, 1'b0);
        tests_run++;
        if (pred_taken !== 1'b1 || mispred_count !== 32'd1 || mispredict !== 1'b1) begin
            tests_failed++;
            $display("FAIL train_first got pred=%b mis=%0d pulse=%b exp 1/1/1",
                     pred_taken, mispred_count, mispredict);
        end
        apply_update(32'h10, 5'b00001, 1'b1, 1'b0);
        tests_run++;
        if (pred_taken !== 1'b1 || br_count !== 32'd2 || mispred_count !== 32'd2) begin
            tests_failed++;
            $display("FAIL train_second got pred=%b br=%0d mis=%0d exp 1/2/2",
                     pred_taken, br_count, mispred_count);
        end
        for (int i = 0; i < 4; i++) begin
            apply_update(32'h10, 5'b00001, 1'b0, 1'b0);
            tests_run++;
            if (pred_taken !== exp_pred[i]) begin
                tests_failed++;
                $display("FAIL train_nt step=%0d got=%b exp=%b", i, pred_taken, exp_pred[i]);
            end
        end
        tests_run++;
        if (br_count !== 32'd6 || mispred_count !== 32'd2 || mispredict !== 1'b0) begin
            tests_failed++;
            $display("FAIL train_stats got br=%0d mis=%0d pulse=%b exp 6/2/0",
                     br_count, mispred_count, mispredict);
        end
    endtask

    task automatic test_invalid_brop();
        logic [4:0] codes [4];
        codes[0] = 5'b00000; codes[1] = 5'b00111; codes[2] = 5'b11111; codes[3] = 5'bxxxxx;
        pc_f = 32'h10;
        for (int i = 0; i < 4; i++) begin
            apply_update(32'h10, codes[i], 1'b1, 1'b0);
            apply_update(32'h10, codes[i], 1'b1, 1'b0);
            tests_run++;
            if (pred_taken !== 1'b0 || br_count !== 32'd6 || mispred_count !== 32'd2 ||
                mispredict !== 1'b0) begin
                tests_failed++;
                $display("FAIL invalid_brop code=%b got pred=%b br=%0d mis=%0d pulse=%b exp 0/6/2/0",
                         codes[i], pred_taken, br_count, mispred_count, mispredict);
            end
        end
    endtask

    task automatic test_aliasing();
        logic [31:0] pcs [5];
        logic        exp  [5];
        pcs[0] = 32'h04; exp[0] = 1'b1;
        pcs[1] = 32'h44; exp[1] = 1'b1;
        pcs[2] = 32'h05; exp[2] = 1'b1;
        pcs[3] = 32'h08; exp[3] = 1'b0;
        pcs[4] = 32'h10; exp[4] = 1'b0;
        apply_update(32'h04, 5'b00010, 1'b1, 1'b0);
        apply_update(32'h04, 5'b00011, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            pc_f = pcs[i];
            #1;
            tests_run++;
            if (pred_taken !== exp[i]) begin
                tests_failed++;
                $display("FAIL alias pc=%h got=%b exp=%b", pcs[i], pred_taken, exp[i]);
            end
        end
    endtask

    task automatic test_read_during_update();
        @(negedge clk);
        pc_f      = 32'h20;
        upd_pc    = 32'h20;
        upd_brop  = 5'b00100;
        upd_taken = 1'b1;
        upd_pred  = 1'b0;
        #1;
        tests_run++;
        if (pred_taken !== 1'b0) begin
            tests_failed++;
            $display("FAIL same_cycle_pre got=%b exp=0", pred_taken);
        end
        @(posedge clk);
        #1;
        upd_brop = 5'b00000;
        tests_run++;
        if (pred_taken !== 1'b1) begin
            tests_failed++;
            $display("FAIL same_cycle_post got=%b exp=1", pred_taken);
        end
    endtask

    task automatic test_reset_priority_and_wrap();
        apply_update(32'h10, 5'b00101, 1'b1, 1'b0);
        apply_update(32'h10, 5'b00101, 1'b1, 1'b1);
        pc_f = 32'h10;
        #1;
        tests_run++;
        if (pred_taken !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_train got=%b exp=1", pred_taken);
        end
        @(negedge clk);
        rst = 1'b1;
        upd_pc = 32'h10; upd_brop = 5'b00001; upd_taken = 1'b1; upd_pred = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        upd_brop = 5'b00000;
        tests_run++;
        if (pred_taken !== 1'b0 || br_count !== 32'd0 || mispred_count !== 32'd0 ||
            mispredict !== 1'b0 || br_count4 !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_priority got pred=%b br=%0d mis=%0d pulse=%b br4=%0d exp 0/0/0/0/0",
                     pred_taken, br_count, mispred_count, mispredict, br_count4);
        end
        pc_f = 32'h20;
        #1;
        tests_run++;
        if (pred_taken !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_clears_0x20 got=%b exp=0", pred_taken);
        end
        for (int i = 0; i < 16; i++) begin
            apply_update(32'h30, 5'b00110, 1'b1, 1'b1);
            if (i == 14) begin
                tests_run++;
                if (br_count4 !== 4'hF) begin
                    tests_failed++;
                    $display("FAIL wrap_allones got=%0d exp=15", br_count4);
                end
            end
        end
        tests_run++;
        if (br_count4 !== 4'd0 || br_count !== 32'd16 || mispred_count4 !== 4'd0) begin
            tests_failed++;
            $display("FAIL wrap got br4=%0d br=%0d mis4=%0d exp 0/16/0",
                     br_count4, br_count, mispred_count4);
        end
    endtask

    initial begin
        test_reset();
        test_training();
        test_invalid_brop();
        test_aliasing();
        test_read_during_update();
        test_reset_priority_and_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
